// File: rtl/init_sbox_fill.sv
`default_nettype none
// ============================================================================
//  Module      : init_sbox_fill
//  Description : ARC4 initialisation stage. On one accepted start request it
//                writes the identity permutation S[i] = i into the 256-entry
//                S-box memory, one entry per clock, then parks in DONE.
//                Optional build macro INIT_REARM_EN: DONE lasts one cycle and
//                the block returns to IDLE, ready for a new start request.
//                Without it, DONE is held until rst_n is asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module init_sbox_fill (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] addr,
    output logic [7:0] wrdata,
    output logic       wren
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] C_LAST_ADDR = 8'd255;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_addr;
    logic [7:0] w_addr_nxt;

    // State and address registers; reset parks on the idle S[0]=0 write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // Next-state and next-address decode; the counter saturates at 255.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        case (r_state)
            S_IDLE: begin
                // S[0]=0 is written during the accepting cycle itself.
                if (en) begin
                    w_state_nxt = S_WRITE;
                    w_addr_nxt  = 8'd1;
                end else begin
                    w_addr_nxt  = 8'd0;
                end
            end
            S_WRITE: begin
                if (r_addr == C_LAST_ADDR) begin
                    w_state_nxt = S_DONE;
                    w_addr_nxt  = C_LAST_ADDR;
                end else begin
                    w_addr_nxt  = r_addr + 8'd1;
                end
            end
            S_DONE: begin
`ifdef INIT_REARM_EN
                w_state_nxt = S_IDLE;
                w_addr_nxt  = 8'd0;
`else
                w_state_nxt = S_DONE;
                w_addr_nxt  = C_LAST_ADDR;
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_addr_nxt  = 8'd0;
            end
        endcase
    end

    // Outputs decode from registered state only; en never reaches them.
    always_comb begin
        rdy    = (r_state == S_IDLE);
        wren   = (r_state == S_IDLE) || (r_state == S_WRITE);
        addr   = r_addr;
        wrdata = r_addr;
    end

endmodule
`default_nettype wire

// File: tb/tb_init_sbox_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_init_sbox_fill
//  Description : Directed self-checking bench for init_sbox_fill.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_init_sbox_fill;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       rdy;
    logic [7:0] addr;
    logic [7:0] wrdata;
    logic       wren;

    int checks = 0;
    int errors = 0;

    // Observation vector: {rdy, wren, addr, wrdata}
    logic [17:0] w_obs;
    assign w_obs = {rdy, wren, addr, wrdata};

    localparam logic [17:0] C_IDLE_VEC = {1'b1, 1'b1, 8'd0,   8'd0};
    localparam logic [17:0] C_DONE_VEC = {1'b0, 1'b0, 8'd255, 8'd255};

    init_sbox_fill dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .rdy    (rdy),
        .addr   (addr),
        .wrdata (wrdata),
        .wren   (wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset values, release with en=1, first two WRITE cycles.
    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b1;
        #12;
        checks++;
        if (w_obs !== C_IDLE_VEC) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", w_obs, C_IDLE_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (w_obs !== C_IDLE_VEC) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", w_obs, C_IDLE_VEC);
        end
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (w_obs !== {1'b0, 1'b1, 8'd1, 8'd1}) begin
            errors++;
            $display("FAIL first_write: got %h expected %h", w_obs, {1'b0, 1'b1, 8'd1, 8'd1});
        end
        @(negedge clk);
        checks++;
        if (w_obs !== {1'b0, 1'b1, 8'd2, 8'd2}) begin
            errors++;
            $display("FAIL second_write: got %h expected %h", w_obs, {1'b0, 1'b1, 8'd2, 8'd2});
        end
        // Return to IDLE for the next scenario.
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Full 0..255 fill from IDLE; optionally toggles en during WRITE.
    task automatic test_full_sequence(input string tag, input bit toggle);
        int  exp_a;
        int  nwr;
        bit  done;
        exp_a = 0;
        nwr   = 0;
        done  = 1'b0;
        checks++;
        if (w_obs !== C_IDLE_VEC) begin
            errors++;
            $display("FAIL %s_start_idle: got %h expected %h", tag, w_obs, C_IDLE_VEC);
        end
        en = 1'b1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (wren) begin
                checks++;
                if ({addr, wrdata} !== {exp_a[7:0], exp_a[7:0]}) begin
                    errors++;
                    $display("FAIL %s_write: got addr=%0d wrdata=%0d expected %0d",
                             tag, addr, wrdata, exp_a);
                end
                exp_a++;
                nwr++;
            end else begin
                done = 1'b1;
            end
            if (!done) begin
                @(posedge clk);
                @(negedge clk);
                en = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        en = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: wren still %b after 300 cycles, expected 0", tag, wren);
        end
        checks++;
        if (nwr !== 256) begin
            errors++;
            $display("FAIL %s_write_count: got %0d expected 256", tag, nwr);
        end
        checks++;
        if (w_obs !== C_DONE_VEC) begin
            errors++;
            $display("FAIL %s_done: got %h expected %h", tag, w_obs, C_DONE_VEC);
        end
    endtask

`ifndef INIT_REARM_EN
    // DONE is sticky regardless of en activity.
    task automatic test_done_sticky;
        for (int i = 0; i < 20; i++) begin
            en = 1'(i % 2);
            @(negedge clk);
            checks++;
            if (w_obs !== C_DONE_VEC) begin
                errors++;
                $display("FAIL done_sticky[%0d]: got %h expected %h", i, w_obs, C_DONE_VEC);
            end
        end
        en = 1'b0;
    endtask
`else
    // DONE lasts one cycle, then IDLE; a second start refills identically.
    task automatic test_rearm;
        @(negedge clk);
        checks++;
        if (w_obs !== C_IDLE_VEC) begin
            errors++;
            $display("FAIL rearm_idle: got %h expected %h", w_obs, C_IDLE_VEC);
        end
        test_full_sequence("rearm", 1'b0);
        @(negedge clk);
        checks++;
        if (w_obs !== C_IDLE_VEC) begin
            errors++;
            $display("FAIL rearm_idle2: got %h expected %h", w_obs, C_IDLE_VEC);
        end
    endtask
`endif

    // Asynchronous reset mid-WRITE, then a complete rerun from address 0.
    task automatic test_async_reset;
        bit hit;
        hit = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            @(negedge clk);
            en = 1'b0;
            if (addr == 8'd100) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL areset_reach100: got addr=%0d expected 100", addr);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (w_obs !== C_IDLE_VEC) begin
            errors++;
            $display("FAIL areset_immediate: got %h expected %h", w_obs, C_IDLE_VEC);
        end
        @(negedge clk);
        checks++;
        if (w_obs !== C_IDLE_VEC) begin
            errors++;
            $display("FAIL areset_held: got %h expected %h", w_obs, C_IDLE_VEC);
        end
        rst_n = 1'b1;
        test_full_sequence("rerun", 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        test_reset();
        test_full_sequence("fill", 1'b1);
`ifndef INIT_REARM_EN
        test_done_sticky();
`else
        test_rearm();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
